// File: rtl/mem_stage.sv
// MEM pipeline stage: captures the EX instruction, consumes one-cycle SRAM read
// data (buffering it across WB stalls), extracts load data and forwards to WB/ID.
module mem_stage #(
  parameter logic [31:0] PC_RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_alu_result,
  input  logic        es_res_from_mem,
  input  logic [2:0]  es_load_op,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_final_result,
  output logic        ms_res_from_mem
);

  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [31:0] pc_q, pc_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] alu_q, alu_d;
  logic        res_mem_q, res_mem_d;
  logic [2:0]  load_op_q, load_op_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_data_q, hold_data_d;

  logic        ms_ready_go;
  logic        enter, leave, capture;
  logic [31:0] raw_word, load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = valid_q && ms_ready_go;

  assign enter   = es_to_ms_valid && ms_allowin;
  assign leave   = valid_q && ws_allowin;
  // rdata is only valid in the first MEM cycle; keep it if WB refuses us then
  assign capture = first_q && valid_q && res_mem_q && !ws_allowin;

  always_comb begin
    valid_d     = valid_q;
    first_d     = enter;
    pc_d        = pc_q;
    rf_we_d     = rf_we_q;
    waddr_d     = waddr_q;
    alu_d       = alu_q;
    res_mem_d   = res_mem_q;
    load_op_d   = load_op_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (ms_allowin) valid_d = es_to_ms_valid;
    if (enter) begin
      pc_d      = es_pc;
      rf_we_d   = es_rf_we;
      waddr_d   = es_rf_waddr;
      alu_d     = es_alu_result;
      res_mem_d = es_res_from_mem;
      load_op_d = es_load_op;
    end
    // clearing wins so a newly entering load reads its own fresh rdata
    if (leave || enter) begin
      hold_vld_d = 1'b0;
    end else if (capture) begin
      hold_vld_d  = 1'b1;
      hold_data_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      pc_q        <= PC_RESET_VALUE;
      rf_we_q     <= 1'b0;
      waddr_q     <= 5'd0;
      alu_q       <= 32'd0;
      res_mem_q   <= 1'b0;
      load_op_q   <= 3'd0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      first_q     <= first_d;
      pc_q        <= pc_d;
      rf_we_q     <= rf_we_d;
      waddr_q     <= waddr_d;
      alu_q       <= alu_d;
      res_mem_q   <= res_mem_d;
      load_op_q   <= load_op_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign raw_word = (first_q || !hold_vld_q) ? data_sram_rdata : hold_data_q;

  always_comb begin
    sel_byte = raw_word[7:0];
    case (alu_q[1:0])
      2'd1:    sel_byte = raw_word[15:8];
      2'd2:    sel_byte = raw_word[23:16];
      2'd3:    sel_byte = raw_word[31:24];
      default: sel_byte = raw_word[7:0];
    endcase
    sel_half = alu_q[1] ? raw_word[31:16] : raw_word[15:0];
    case (load_op_q)
      3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b101:  load_data = {24'd0, sel_byte};
      3'b010:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b110:  load_data = {16'd0, sel_half};
      default: load_data = raw_word;
    endcase
  end

  assign ms_pc           = pc_q;
  assign ms_rf_we        = valid_q && rf_we_q;
  assign ms_rf_waddr     = waddr_q;
  assign ms_res_from_mem = valid_q && res_mem_q;
  assign ms_final_result = ms_res_from_mem ? load_data : alu_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load extraction, stall hold, back-to-back,
// non-load path and asynchronous reset during a stalled load.
module tb_mem_stage;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_final_result;
  logic        ms_res_from_mem;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.PC_RESET_VALUE(RST_PC)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_alu_result(es_alu_result), .es_res_from_mem(es_res_from_mem),
    .es_load_op(es_load_op), .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_final_result(ms_final_result),
    .ms_res_from_mem(ms_res_from_mem)
  );

  // Present one instruction at the next edge; called just after a rising edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] op,
                      input logic is_ld, input logic [4:0] wa);
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    es_alu_result   = addr;
    es_load_op      = op;
    es_res_from_mem = is_ld;
    es_rf_we        = 1'b1;
    es_rf_waddr     = wa;
    @(posedge clk); #1;
    es_to_ms_valid  = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", ms_to_ws_valid); end
    n_chk++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL rst_allowin got=%0b exp=1", ms_allowin); end
    n_chk++; if (ms_pc !== RST_PC) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", ms_pc, RST_PC); end
    n_chk++; if (ms_rf_we !== 1'b0 || ms_res_from_mem !== 1'b0) begin n_err++; $display("FAIL rst_gated got=%0b%0b exp=00", ms_rf_we, ms_res_from_mem); end
    n_chk++; if (ms_rf_waddr !== 5'd0 || ms_final_result !== 32'd0) begin n_err++; $display("FAIL rst_payload got=%0d/%h exp=0/0", ms_rf_waddr, ms_final_result); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word;
    ws_allowin = 1'b1;
    send(32'h1C00_0010, 32'h100, 3'b000, 1'b1, 5'd3);
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (ms_final_result !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ldw_result got=%h exp=deadbeef", ms_final_result); end
    n_chk++; if (ms_to_ws_valid !== 1'b1 || ms_rf_we !== 1'b1 || ms_res_from_mem !== 1'b1) begin n_err++; $display("FAIL ldw_flags got=%0b%0b%0b exp=111", ms_to_ws_valid, ms_rf_we, ms_res_from_mem); end
    n_chk++; if (ms_pc !== 32'h1C00_0010 || ms_rf_waddr !== 5'd3) begin n_err++; $display("FAIL ldw_pc got=%h/%0d exp=1c000010/3", ms_pc, ms_rf_waddr); end
    @(posedge clk); #1;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if (ms_to_ws_valid !== 1'b0 || ms_rf_we !== 1'b0 || ms_res_from_mem !== 1'b0) begin n_err++; $display("FAIL ldw_bubble got=%0b%0b%0b exp=000", ms_to_ws_valid, ms_rf_we, ms_res_from_mem); end
    @(posedge clk); #1;
  endtask

  task automatic test_extract;
    logic [2:0]  op  [10] = '{3'b001, 3'b101, 3'b001, 3'b001, 3'b101,
                              3'b010, 3'b110, 3'b010, 3'b110, 3'b011};
    logic [31:0] adr [10] = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h100,
                              32'h102, 32'h102, 32'h100, 32'h103, 32'h102};
    logic [31:0] rd  [10] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                              32'h80017FFE, 32'h80017FFE, 32'h80017FFE, 32'h80017FFE, 32'h80017FFE};
    logic [31:0] exp [10] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFFFFFF, 32'h00000001,
                              32'hFFFF8001, 32'h00008001, 32'h00007FFE, 32'h00008001, 32'h80017FFE};
    ws_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'h1C00_0100 + i, adr[i], op[i], 1'b1, 5'd7);
      data_sram_rdata = rd[i];
      @(negedge clk);
      n_chk++; if (ms_final_result !== exp[i]) begin n_err++; $display("FAIL extract[%0d] op=%b addr=%h got=%h exp=%h", i, op[i], adr[i], ms_final_result, exp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    ws_allowin = 1'b0;
    send(32'h1C00_0200, 32'h200, 3'b000, 1'b1, 5'd9);
    data_sram_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        data_sram_rdata = 32'hAAAA_AAAA;
        if (c == 3) ws_allowin = 1'b1;
      end
      @(negedge clk);
      n_chk++; if (ms_final_result !== 32'h1234_5678 || ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got=%h/%0b exp=12345678/1", c, ms_final_result, ms_to_ws_valid); end
      n_chk++; if (ms_allowin !== (c == 3)) begin n_err++; $display("FAIL stall_allowin[%0d] got=%0b exp=%0b", c, ms_allowin, c == 3); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL stall_retire got=%0b exp=0", ms_to_ws_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b1;
    es_rf_we        = 1'b1;
    es_res_from_mem = 1'b1;
    es_pc = 32'h1C00_0300; es_alu_result = 32'h301; es_load_op = 3'b101; es_rf_waddr = 5'd1;
    @(posedge clk); #1;
    es_pc = 32'h1C00_0304; es_alu_result = 32'h302; es_load_op = 3'b010; es_rf_waddr = 5'd2;
    data_sram_rdata = 32'h0000_C300;
    @(negedge clk);
    n_chk++; if (ms_final_result !== 32'h0000_00C3 || ms_pc !== 32'h1C00_0300) begin n_err++; $display("FAIL b2b_first got=%h/%h exp=000000c3/1c000300", ms_final_result, ms_pc); end
    @(posedge clk); #1;
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'hF00D_0000;
    @(negedge clk);
    n_chk++; if (ms_final_result !== 32'hFFFF_F00D || ms_pc !== 32'h1C00_0304 || ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got=%h/%h exp=fffff00d/1c000304", ms_final_result, ms_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_nonload;
    ws_allowin = 1'b1;
    send(32'h1C00_0400, 32'h0000_0042, 3'b000, 1'b0, 5'd5);
    data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    n_chk++; if (ms_final_result !== 32'h42 || ms_rf_we !== 1'b1 || ms_res_from_mem !== 1'b0 || ms_rf_waddr !== 5'd5) begin n_err++; $display("FAIL add_result got=%h we=%0b mem=%0b wa=%0d exp=42/1/0/5", ms_final_result, ms_rf_we, ms_res_from_mem, ms_rf_waddr); end
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    n_chk++; if (ms_final_result !== 32'h42) begin n_err++; $display("FAIL add_rdata_indep got=%h exp=42", ms_final_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ws_allowin = 1'b0;
    send(32'h1C00_0500, 32'h500, 3'b000, 1'b1, 5'd11);
    data_sram_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    data_sram_rdata = 32'h2222_2222;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (ms_to_ws_valid !== 1'b0 || ms_rf_we !== 1'b0 || ms_res_from_mem !== 1'b0) begin n_err++; $display("FAIL amid_gated got=%0b%0b%0b exp=000", ms_to_ws_valid, ms_rf_we, ms_res_from_mem); end
    n_chk++; if (ms_pc !== RST_PC || ms_allowin !== 1'b1) begin n_err++; $display("FAIL amid_pc got=%h/%0b exp=%h/1", ms_pc, ms_allowin, RST_PC); end
    @(posedge clk); #1;
    reset = 1'b0;
    ws_allowin = 1'b1;
    send(32'h1C00_0600, 32'h600, 3'b000, 1'b1, 5'd12);
    data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    n_chk++; if (ms_final_result !== 32'h5555_5555 || ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL amid_fresh got=%h/%0b exp=55555555/1", ms_final_result, ms_to_ws_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_pc = '0; es_rf_we = 1'b0; es_rf_waddr = '0;
    es_alu_result = '0; es_res_from_mem = 1'b0; es_load_op = '0; data_sram_rdata = '0;
    ws_allowin = 1'b1;
    test_reset;
    test_word;
    test_extract;
    test_stall;
    test_back_to_back;
    test_nonload;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. It sits downstream of the EX stage on the valid/allowin handshake and is the response end of the data SRAM interface that EX drives.
- Captures the instruction leaving EX and consumes the synchronous data SRAM read data, which arrives one cycle after the request.
- Performs load byte/halfword selection and sign/zero extension, then presents the final result to WB along with register-file forwarding information for ID.
- Holds the SRAM read data in a local buffer while WB stalls, because SRAM rdata is valid for one cycle only.

Parameters:
PC_RESET_VALUE  32'h0000_0000  value of ms_pc after reset

Ports:
clk              in   1   clock, all state on rising edge
reset            in   1   asynchronous, active-high reset
es_to_ms_valid   in   1   EX has an instruction ready to transfer
ms_allowin       out  1   MEM can accept an instruction this cycle
es_pc            in   32  PC of EX instruction
es_rf_we         in   1   instruction writes the register file
es_rf_waddr      in   5   destination register
es_alu_result    in   32  ALU result; for loads, the byte address
es_res_from_mem  in   1   instruction is a load
es_load_op       in   3   000 W, 001 B, 010 H, 101 BU, 110 HU; any other code is treated as W
data_sram_rdata  in   32  SRAM read data, valid the cycle after the request
ws_allowin       in   1   WB can accept
ms_to_ws_valid   out  1   MEM result valid toward WB
ms_pc            out  32  PC of MEM instruction
ms_rf_we         out  1   register write enable, gated with ms_valid (used for WB and ID hazard detection)
ms_rf_waddr      out  5   destination register
ms_final_result  out  32  load data if load, else ALU result
ms_res_from_mem  out  1   MEM holds a load (gated with ms_valid)

Behaviour:
- Reset (asynchronous) values:
  - ms_valid = 0, so ms_to_ms_valid, ms_rf_we and ms_res_from_mem are all 0.
  - ms_pc = PC_RESET_VALUE.
  - ms_rf_waddr = 0; stored ALU result = 0; load op = 0.
  - Hold buffer valid flag (hold_vld) = 0; hold buffer data = 0.
- Handshake:
  - ms_ready_go = 1 always.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
  - On a clock edge with ms_allowin = 1, ms_valid <= es_to_ms_valid.
  - Payload registers load only when es_to_ms_valid && ms_allowin; otherwise they hold.
- Read-data timing:
  - The SRAM request was issued by EX in the transfer cycle, so data_sram_rdata belongs to the MEM instruction in its first MEM cycle only.
  - A first_cycle flag is set on transfer-in and cleared on the next edge.
  - Raw load word = first_cycle ? data_sram_rdata : hold_data.
- Hold buffer:
  - Capture: when first_cycle && ms_valid && ms_res_from_mem && !ws_allowin, then hold_data <= data_sram_rdata and hold_vld <= 1.
  - Clear: hold_vld is cleared when the instruction leaves (ms_valid && ws_allowin) or a new instruction enters.
  - Simultaneous leave and enter in the same cycle: clear takes priority, and the new instruction uses data_sram_rdata in its own first cycle.
  - For a non-load, the buffer is never written and is don't-care.
- Load extraction (combinational, all on the raw load word):
  - Byte: addr[1:0] selects byte 0..3 (bits 7:0, 15:8, 23:16, 31:24). B sign-extends, BU zero-extends.
  - Halfword: addr[1] selects bits 15:0 or 31:16; addr[0] is ignored (no alignment exception in this block). H sign-extends, HU zero-extends.
  - W passes the whole word and ignores addr[1:0].
- ms_final_result = ms_res_from_mem ? extracted load data : stored ALU result.
- ms_final_result is stable for the whole residency of the instruction, including multi-cycle WB stalls.
- Back-to-back loads with ws_allowin = 1 continuously: one instruction per cycle, and each uses the rdata of its own first cycle.
- Bubbles: with es_to_ms_valid = 0 and ms_allowin = 1, ms_valid drops to 0 and the gated outputs drop to 0.
- Reset mid-operation: the instruction and hold buffer are discarded immediately, and outputs go to reset values without waiting for a clock edge.

Test Plan:
- ld.w, addr 0x100, rdata 0xDEADBEEF in the cycle after transfer, ws_allowin = 1 -> ms_final_result = 0xDEADBEEF and ms_to_ws_valid = 1 for exactly 1 cycle.
- Byte loads with rdata 0x80FF7F01:
  - ld.b, addr 0x103 -> 0xFFFFFF80.
  - ld.bu, addr 0x103 -> 0x00000080.
  - ld.b, addr 0x101 -> 0x0000007F.
- Halfword loads with rdata 0x8001_7FFE:
  - ld.h, addr 0x102 -> 0xFFFF8001.
  - ld.hu, addr 0x102 -> 0x00008001.
  - ld.h, addr 0x100 -> 0x00007FFE.
- ld.w entering with ws_allowin = 0 for 3 cycles, rdata 0x12345678 in the first cycle then 0xAAAAAAAA afterward:
  - ms_final_result stays 0x12345678 all 4 cycles and ms_allowin = 0 during the stall.
  - The instruction retires when ws_allowin rises.
- Non-load add with es_alu_result 0x00000042 and rf_waddr 5 -> ms_final_result = 0x42, ms_rf_we = 1, ms_res_from_mem = 0; rdata changes have no effect.
- Assert reset asynchronously while a stalled load has hold_vld = 1 -> ms_to_ws_valid = 0, ms_rf_we = 0, ms_pc = PC_RESET_VALUE before the next edge; the first load after reset uses fresh rdata.
